// File: rtl/tx0_flexo_pkg.sv
// -----------------------------------------------------------------------------
// tx0_flexo_pkg
//   Shared definitions for the TX-0 flexowriter UART bridge.
//   - Field positions of the transmitted byte:
//       bit7 = punch(1)/print(0), bit6 = seventh hole, bits5:0 = character
//   - Width of the bit-period counters
//   - State encodings for the TX and RX state machines
// -----------------------------------------------------------------------------
package tx0_flexo_pkg;

  localparam int TAG_PUNCH = 7;
  localparam int TAG_7TH   = 6;
  localparam int CODE_MSB  = 5;

  // Bit-period counters are sized for the largest legal CLKDIV (65535).
  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP,
    TX_DONE
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage : tx0_flexo_pkg

// File: rtl/flexo_uart_rx.sv
// -----------------------------------------------------------------------------
// flexo_uart_rx
//   8N1 serial receiver for the flexowriter input path.
//   The asynchronous line is synchronised, a falling edge starts a frame, the
//   start bit is re-checked half a bit later, and data/stop are sampled at the
//   middle of each bit. Only the low six data bits are kept; bits 7:6 are
//   received but discarded. A stop bit of 0 discards the byte, sets a sticky
//   frame-error flag and holds off until the line returns high.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   i_uart_rx    in   serial input (asynchronous)
//   o_code       out  last valid received character (bits 5:0 of the byte)
//   o_strobe     out  one-cycle pulse, coincident with o_code being updated
//   o_frame_err  out  sticky: a received stop bit was 0
// -----------------------------------------------------------------------------
module flexo_uart_rx
  import tx0_flexo_pkg::*;
#(
  parameter int CLKDIV = 434
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_uart_rx,
  output logic [CODE_MSB:0] o_code,
  output logic              o_strobe,
  output logic              o_frame_err
);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKDIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKDIV / 2 - 1);

  rx_state_t         r_state;
  rx_state_t         w_next;
  logic [1:0]        r_sync;
  logic              r_rx_prev;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_bit_idx;
  logic [CODE_MSB:0] r_shift;
  logic              r_wait_high;
  logic [CODE_MSB:0] r_code;
  logic              r_strobe;
  logic              r_frame_err;

  logic w_rx;
  logic w_fall;
  logic w_half;
  logic w_bit_end;

  assign w_rx      = r_sync[1];
  assign w_fall    = r_rx_prev & ~w_rx;
  assign w_half    = (r_cnt == HALF_LAST);
  assign w_bit_end = (r_cnt == BIT_LAST);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RX_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  // NOTE: w_next gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      RX_IDLE:  if (w_fall) w_next = RX_START;
      // Line back high at mid-start means the edge was a glitch.
      RX_START: if (w_half) w_next = w_rx ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_bit_end && (r_bit_idx == 3'd7)) w_next = RX_STOP;
      RX_STOP: begin
        if (r_wait_high) begin
          if (w_rx) w_next = RX_IDLE;
        end else if (w_bit_end && w_rx) begin
          w_next = RX_IDLE;
        end
      end
      default:  w_next = RX_IDLE;
    endcase
  end

  // Datapath: synchroniser, bit counter, shift register and outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // The line idles high, so the synchroniser resets to 1 to avoid a false
      // start edge right after reset.
      r_sync      <= 2'b11;
      r_rx_prev   <= 1'b1;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_wait_high <= 1'b0;
      r_code      <= '0;
      r_strobe    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_uart_rx};
      r_rx_prev <= w_rx;
      r_strobe  <= 1'b0;

      // Reloading on every boundary keeps each sample point referenced to the
      // previous one, so no error accumulates across the frame.
      if ((w_next != r_state) || w_bit_end) begin
        r_cnt <= '0;
      end else if (r_state != RX_IDLE) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (r_state == RX_START) begin
        r_bit_idx <= '0;
      end else if ((r_state == RX_DATA) && w_bit_end) begin
        if (r_bit_idx <= 3'd5) begin
          r_shift[r_bit_idx] <= w_rx;
        end
        r_bit_idx <= r_bit_idx + 1'b1;
      end

      if (r_state != RX_STOP) begin
        r_wait_high <= 1'b0;
      end else if (!r_wait_high && w_bit_end) begin
        if (w_rx) begin
          r_code   <= r_shift;
          r_strobe <= 1'b1;
        end else begin
          r_frame_err <= 1'b1;
          r_wait_high <= 1'b1;
        end
      end
    end
  end

  assign o_code      = r_code;
  assign o_strobe    = r_strobe;
  assign o_frame_err = r_frame_err;

endmodule : flexo_uart_rx

// File: rtl/flexo_uart.sv
// -----------------------------------------------------------------------------
// flexo_uart
//   Bridge between the TX-0 front panel flexowriter port and board UART pins.
//   Print/punch requests (rising edges) are sent as one 8N1 byte each:
//     bit7 = punch(1)/print(0), bit6 = seventh hole, bits5:0 = flexo_out
//   flexo_complete pulses once the stop bit has gone out. Received bytes
//   update flexo_in and pulse flexo_to_lr. TX and RX run independently.
//
//   Request-to-complete latency is 10*CLKDIV+2 cycles: one cycle to register
//   the edge, one to launch the start bit, ten bit periods, then DONE.
//
// Optional feature (macro FLEXO_UART_PACE_EN):
//   When defined, DONE is also held off until PACE_CYCLES have elapsed since
//   the request edge, modelling typewriter speed. Requests during the wait are
//   still overruns. When undefined, PACE_CYCLES has no effect.
//
// Ports:
//   clk                in   system clock
//   reset              in   asynchronous active-low reset
//   flexo_start_print  in   print request (rising edge)
//   flexo_start_punch  in   punch request (rising edge)
//   flexo_out          in   character code, sampled on the request edge
//   flexo_7th_hole     in   seventh-hole flag, sampled on the request edge
//   flexo_complete     out  one-cycle pulse when a request is finished
//   flexo_in           out  last received character code
//   flexo_to_lr        out  one-cycle pulse when flexo_in is updated
//   uart_rx            in   serial input (asynchronous)
//   uart_tx            out  serial output, idles high
//   tx_overrun         out  sticky: a request arrived while busy
//   rx_frame_err       out  sticky: a received stop bit was 0
// -----------------------------------------------------------------------------
module flexo_uart
  import tx0_flexo_pkg::*;
#(
  parameter int CLKDIV      = 434,
  parameter int PACE_CYCLES = 5000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flexo_start_print,
  input  logic              flexo_start_punch,
  input  logic [CODE_MSB:0] flexo_out,
  input  logic              flexo_7th_hole,
  output logic              flexo_complete,
  output logic [CODE_MSB:0] flexo_in,
  output logic              flexo_to_lr,
  input  logic              uart_rx,
  output logic              uart_tx,
  output logic              tx_overrun,
  output logic              rx_frame_err
);

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKDIV - 1);

  // ---------------------------------------------------------------------------
  // Request edge detection and capture
  // ---------------------------------------------------------------------------
  logic       r_prev_print;
  logic       r_prev_punch;
  logic       r_req;
  logic [7:0] r_req_byte;
  logic       r_overrun;

  logic       w_print_edge;
  logic       w_punch_edge;
  logic       w_any_edge;
  logic       w_tx_free;
  logic [7:0] w_req_byte;

  assign w_print_edge = flexo_start_print & ~r_prev_print;
  assign w_punch_edge = flexo_start_punch & ~r_prev_punch;
  assign w_any_edge   = w_print_edge | w_punch_edge;

  // Simultaneous print and punch edges collapse into one punch-tagged byte.
  always_comb begin
    w_req_byte                = '0;
    w_req_byte[TAG_PUNCH]     = w_punch_edge;
    w_req_byte[TAG_7TH]       = flexo_7th_hole;
    w_req_byte[CODE_MSB:0]    = flexo_out;
  end

  // ---------------------------------------------------------------------------
  // TX state machine
  // ---------------------------------------------------------------------------
  tx_state_t        r_tx_state;
  tx_state_t        w_tx_next;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_stop_over;

  logic w_bit_end;
  logic w_pace_ok;

  assign w_bit_end = (r_bit_cnt == BIT_LAST);

  // A registered-but-not-launched request also counts as busy.
  assign w_tx_free = (r_tx_state == TX_IDLE) && !r_req;

`ifdef FLEXO_UART_PACE_EN
  // Cycles since the accepted request edge, saturating.
  logic [31:0] r_pace_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pace_cnt <= '0;
    end else if (w_any_edge && w_tx_free) begin
      r_pace_cnt <= '0;
    end else if (r_pace_cnt != '1) begin
      r_pace_cnt <= r_pace_cnt + 1'b1;
    end
  end

  // Counter is 0 the cycle after the edge, so DONE appears no earlier than
  // PACE_CYCLES cycles after the edge.
  assign w_pace_ok = (r_pace_cnt >= 32'(PACE_CYCLES - 1));
`else
  // Pacing disabled: the condition is always satisfied.
  assign w_pace_ok = (PACE_CYCLES >= 0);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_state <= TX_IDLE;
    end else begin
      r_tx_state <= w_tx_next;
    end
  end

  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      TX_IDLE:  if (r_req) w_tx_next = TX_START;
      TX_START: if (w_bit_end) w_tx_next = TX_DATA;
      TX_DATA:  if (w_bit_end && (r_bit_idx == 3'd7)) w_tx_next = TX_STOP;
      // With pacing the line simply stays at the stop level until released.
      TX_STOP:  if ((w_bit_end || r_stop_over) && w_pace_ok) w_tx_next = TX_DONE;
      TX_DONE:  w_tx_next = TX_IDLE;
      default:  w_tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev_print <= 1'b0;
      r_prev_punch <= 1'b0;
      r_req        <= 1'b0;
      r_req_byte   <= '0;
      r_overrun    <= 1'b0;
      r_bit_cnt    <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_stop_over  <= 1'b0;
    end else begin
      r_prev_print <= flexo_start_print;
      r_prev_punch <= flexo_start_punch;

      // A pending request is always consumed on the following cycle.
      if (r_req) begin
        r_req <= 1'b0;
      end

      if (w_any_edge) begin
        if (w_tx_free) begin
          r_req      <= 1'b1;
          r_req_byte <= w_req_byte;
        end else begin
          r_overrun  <= 1'b1;
        end
      end

      if ((w_tx_next != r_tx_state) || w_bit_end) begin
        r_bit_cnt <= '0;
      end else if (r_tx_state != TX_IDLE) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end

      if ((r_tx_state == TX_IDLE) && r_req) begin
        r_shift   <= r_req_byte;
        r_bit_idx <= '0;
      end else if ((r_tx_state == TX_DATA) && w_bit_end) begin
        r_shift   <= {1'b0, r_shift[7:1]};
        r_bit_idx <= r_bit_idx + 1'b1;
      end

      if (r_tx_state != TX_STOP) begin
        r_stop_over <= 1'b0;
      end else if (w_bit_end) begin
        r_stop_over <= 1'b1;
      end
    end
  end

  // Line level decoded from state flops; reset forces IDLE and hence a high
  // line immediately.
  always_comb begin
    uart_tx = 1'b1;
    case (r_tx_state)
      TX_START: uart_tx = 1'b0;
      TX_DATA:  uart_tx = r_shift[0];
      default:  uart_tx = 1'b1;
    endcase
  end

  assign flexo_complete = (r_tx_state == TX_DONE);
  assign tx_overrun     = r_overrun;

  // ---------------------------------------------------------------------------
  // RX path
  // ---------------------------------------------------------------------------
  flexo_uart_rx #(
    .CLKDIV (CLKDIV)
  ) u_rx (
    .clk         (clk),
    .reset       (reset),
    .i_uart_rx   (uart_rx),
    .o_code      (flexo_in),
    .o_strobe    (flexo_to_lr),
    .o_frame_err (rx_frame_err)
  );

endmodule : flexo_uart

// File: tb/tb_flexo_uart.sv
// -----------------------------------------------------------------------------
// tb_flexo_uart
//   Scoreboard bench for flexo_uart with CLKDIV=8, pacing disabled.
//   Stimulus pushes expected TX bytes, completion cycles and RX characters into
//   queues; independent monitors pop and compare when the DUT produces them.
// -----------------------------------------------------------------------------
module tb_flexo_uart;

  localparam int CLKDIV = 8;
  localparam int FRAME  = 10 * CLKDIV + 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       flexo_start_print = 1'b0;
  logic       flexo_start_punch = 1'b0;
  logic [5:0] flexo_out = '0;
  logic       flexo_7th_hole = 1'b0;
  logic       flexo_complete;
  logic [5:0] flexo_in;
  logic       flexo_to_lr;
  logic       uart_rx = 1'b1;
  logic       uart_tx;
  logic       tx_overrun;
  logic       rx_frame_err;

  flexo_uart #(
    .CLKDIV      (CLKDIV),
    .PACE_CYCLES (100)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .flexo_start_print (flexo_start_print),
    .flexo_start_punch (flexo_start_punch),
    .flexo_out         (flexo_out),
    .flexo_7th_hole    (flexo_7th_hole),
    .flexo_complete    (flexo_complete),
    .flexo_in          (flexo_in),
    .flexo_to_lr       (flexo_to_lr),
    .uart_rx           (uart_rx),
    .uart_tx           (uart_tx),
    .tx_overrun        (tx_overrun),
    .rx_frame_err      (rx_frame_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rst_epoch = 0;
  always @(negedge reset) rst_epoch <= rst_epoch + 1;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;
  int cpl_cnt = 0;

  logic [7:0]  exp_tx_q[$];
  int unsigned exp_cpl_q[$];
  logic [5:0]  exp_rx_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue one request edge; when accepted is expected, queue the byte and the
  // cycle at which flexo_complete must be seen.
  task automatic request(input bit print, input bit punch, input logic [5:0] code,
                         input bit h7, input bit expect_ok);
    @(posedge clk);
    #1;
    flexo_out         = code;
    flexo_7th_hole    = h7;
    flexo_start_print = print;
    flexo_start_punch = punch;
    if (expect_ok) begin
      exp_tx_q.push_back({punch, h7, code});
      exp_cpl_q.push_back(cyc + FRAME);
    end
    tick(2);
    flexo_start_print = 1'b0;
    flexo_start_punch = 1'b0;
  endtask

  // Drive one 8N1 frame on uart_rx; a zero stop bit is extended by extra_low.
  task automatic send_rx(input logic [7:0] b, input bit stop, input int extra_low);
    uart_rx = 1'b0;
    tick(CLKDIV);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(CLKDIV);
    end
    uart_rx = stop;
    tick(CLKDIV);
    if (!stop) tick(extra_low);
    uart_rx = 1'b1;
    tick(2 * CLKDIV);
  endtask

  // Completion monitor.
  initial begin : mon_cpl
    forever begin
      @(negedge clk);
      if (flexo_complete) begin
        cpl_cnt++;
        if (exp_cpl_q.size() == 0) check("complete_unexpected", exp_cpl_q.size(), 1);
        else check("complete_cycle", cyc, exp_cpl_q.pop_front());
      end
    end
  end

  // RX strobe monitor.
  initial begin : mon_rx
    forever begin
      @(negedge clk);
      if (flexo_to_lr) begin
        strobe_cnt++;
        if (exp_rx_q.size() == 0) check("rx_strobe_unexpected", exp_rx_q.size(), 1);
        else check("rx_char", flexo_in, exp_rx_q.pop_front());
      end
    end
  end

  // Serial line monitor: decodes uart_tx at mid-bit; frames cut by reset are dropped.
  initial begin : mon_tx
    logic [7:0] data;
    logic       start_bit;
    logic       stop_bit;
    int         ep;
    forever begin
      @(negedge clk);
      if (reset && (uart_tx == 1'b0)) begin
        ep = rst_epoch;
        repeat (CLKDIV / 2) @(negedge clk);
        start_bit = uart_tx;
        for (int i = 0; i < 8; i++) begin
          repeat (CLKDIV) @(negedge clk);
          data[i] = uart_tx;
        end
        repeat (CLKDIV) @(negedge clk);
        stop_bit = uart_tx;
        if (ep == rst_epoch) begin
          if (exp_tx_q.size() == 0) begin
            check("tx_frame_unexpected", exp_tx_q.size(), 1);
          end else begin
            check("tx_start_bit", start_bit, 0);
            check("tx_byte", data, exp_tx_q.pop_front());
            check("tx_stop_bit", stop_bit, 1);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int c0;
    int s0;

    // Reset state
    tick(3);
    check("rst_uart_tx", uart_tx, 1);
    check("rst_complete", flexo_complete, 0);
    check("rst_to_lr", flexo_to_lr, 0);
    check("rst_flexo_in", flexo_in, 0);
    check("rst_overrun", tx_overrun, 0);
    check("rst_frame_err", rx_frame_err, 0);
    reset = 1'b1;
    tick(3);

    // Print 6'o52 -> 0x2A, complete 82 cycles after the edge
    request(1'b1, 1'b0, 6'o52, 1'b0, 1'b1);
    tick(FRAME + 10);

    // Punch 6'o77 with seventh hole -> 0xFF
    request(1'b0, 1'b1, 6'o77, 1'b1, 1'b1);
    tick(FRAME + 10);
    check("overrun_after_punch", tx_overrun, 0);

    // Simultaneous print and punch -> one byte tagged punch (0x83)
    c0 = cpl_cnt;
    request(1'b1, 1'b1, 6'o03, 1'b0, 1'b1);
    tick(FRAME + 10);
    check("simul_complete_count", cpl_cnt - c0, 1);

    // Second print edge 20 cycles into a frame is dropped
    c0 = cpl_cnt;
    request(1'b1, 1'b0, 6'o12, 1'b0, 1'b1);
    tick(17);
    request(1'b1, 1'b0, 6'o34, 1'b1, 1'b0);
    tick(FRAME);
    check("overrun_set", tx_overrun, 1);
    check("overrun_complete_count", cpl_cnt - c0, 1);

    // RX 0xC5 -> 6'o05, held across 200 idle cycles
    exp_rx_q.push_back(6'o05);
    send_rx(8'hC5, 1'b1, 0);
    s0 = strobe_cnt;
    tick(200);
    check("rx_hold_code", flexo_in, 6'o05);
    check("rx_idle_no_strobe", strobe_cnt - s0, 0);

    // Bad stop bit, then a valid 0x11
    check("frame_err_clear", rx_frame_err, 0);
    s0 = strobe_cnt;
    send_rx(8'h3C, 1'b0, 3 * CLKDIV);
    check("frame_err_set", rx_frame_err, 1);
    check("frame_err_code_kept", flexo_in, 6'o05);
    check("frame_err_no_strobe", strobe_cnt - s0, 0);
    exp_rx_q.push_back(6'o21);
    send_rx(8'h11, 1'b1, 0);
    check("rx_after_err_code", flexo_in, 6'o21);

    // Full duplex: punch 6'o41 (0xA1) while receiving 0x1B (6'o33)
    exp_rx_q.push_back(6'o33);
    fork
      begin
        request(1'b0, 1'b1, 6'o41, 1'b0, 1'b1);
        tick(FRAME + 10);
      end
      send_rx(8'h1B, 1'b1, 0);
    join

    // Reset during TX data bit 3 of 0x55
    c0 = cpl_cnt;
    request(1'b1, 1'b0, 6'o25, 1'b1, 1'b0);
    tick(33);
    check("tx_bit3_before_reset", uart_tx, 0);
    #2;
    reset = 1'b0;
    #1;
    check("abort_uart_tx_high", uart_tx, 1);
    check("abort_flexo_in_cleared", flexo_in, 0);
    check("abort_overrun_cleared", tx_overrun, 0);
    check("abort_frame_err_cleared", rx_frame_err, 0);
    tick(3);
    reset = 1'b1;
    tick(100);
    check("abort_no_complete", cpl_cnt - c0, 0);

    // Normal request after release: print 6'o41 -> 0x21
    request(1'b1, 1'b0, 6'o41, 1'b0, 1'b1);
    tick(FRAME + 20);

    check("tx_queue_drained", exp_tx_q.size(), 0);
    check("cpl_queue_drained", exp_cpl_q.size(), 0);
    check("rx_queue_drained", exp_rx_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_flexo_uart
